// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   instr_mem_lo / instr_mem_hi : valid word-index window of instruction memory
//   nop                         : encoding captured into IF/ID for a bubble
//   state_e                     : fetch FSM states
//   pc_sel_e                    : next-PC mux select driven into the PC register
//   ifid_act_e                  : IF/ID register update action for the current edge
package instr_fetch_pkg;

  localparam int unsigned instr_mem_lo = 0;
  localparam int unsigned instr_mem_hi = 15;

  localparam logic [31:0] nop = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_HOLD    = 2'd0,
    IFID_BUBBLE  = 2'd1,
    IFID_CAPTURE = 2'd2
  } ifid_act_e;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register (pc_reg block of the fetch stage).
// Holds the PC, selects the next PC (hold / +4 / redirect load) and reports
// whether the current PC lies inside the instruction memory word window.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   sel         : next-PC select
//   target      : redirect byte address (low two bits masked here)
//   pc          : current fetch byte address
//   pc_plus4    : pc + 4, modulo 2^32
//   in_range    : IMEM_LO <= pc[31:2] <= IMEM_HI
module instr_fetch_pc_reg
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_LO  = instr_mem_lo,
  parameter int unsigned IMEM_HI  = instr_mem_hi
) (
  input  logic        clk,
  input  logic        rst_n,
  input  pc_sel_e     sel,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        in_range
);

  // Compare as 33-bit signed so a zero lower bound is not a constant-true test.
  localparam logic signed [32:0] lo_s = $signed(33'(IMEM_LO));
  localparam logic signed [32:0] hi_s = $signed(33'(IMEM_HI));

  logic signed [32:0] word_s;
  logic [31:0]        target_aligned;

  assign pc_plus4       = pc + 32'd4;
  assign word_s         = $signed({3'b000, pc[31:2]});
  assign in_range       = (word_s >= lo_s) && (word_s <= hi_s);
  assign target_aligned = target & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      unique case (sel)
        PC_INC:  pc <= pc_plus4;
        PC_LOAD: pc <= target_aligned;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: initiator side of the combinational instruction
// memory read, IF/ID pipeline register and accepted-instruction counter.
// Optional build macro: FETCH_ALIGN_TRAP_EN (misaligned redirect halts fetch
// and raises a sticky align_fault output instead of being masked).
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   pc / instr              : fetch address out, instruction word back
//   stall, flush            : hold the stage / squash IF/ID
//   redirect, redirect_pc   : branch/jump target load
//   ifid_instr/pc4/valid    : IF/ID pipeline register
//   halted                  : fetch stopped (PC outside memory window)
//   fetch_count             : instructions accepted into IF/ID
//   align_fault             : (FETCH_ALIGN_TRAP_EN only) sticky misaligned redirect
//
// state | meaning
// RUN   | normal fetch, one word per cycle unless stalled/flushed
// HALT  | PC frozen, IF/ID invalid; only redirect or reset leaves
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_LO  = instr_mem_lo,
  parameter int unsigned IMEM_HI  = instr_mem_hi
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
`ifdef FETCH_ALIGN_TRAP_EN
  ,
  output logic        align_fault
`endif
);

  state_e    state, state_nxt;
  pc_sel_e   pc_sel;
  ifid_act_e ifid_act;
  logic      cnt_inc;
  logic      in_range;
  logic      redirect_ok;
  logic      redirect_bad;
  logic [31:0] pc_plus4;

`ifdef FETCH_ALIGN_TRAP_EN
  assign redirect_ok  = redirect && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_ok  = redirect;
  assign redirect_bad = 1'b0;
`endif

  instr_fetch_pc_reg #(
    .RESET_PC(RESET_PC),
    .IMEM_LO (IMEM_LO),
    .IMEM_HI (IMEM_HI)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (pc_sel),
    .target  (redirect_pc),
    .pc      (pc),
    .pc_plus4(pc_plus4),
    .in_range(in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_ok)                       state_nxt = RUN;
    else if (redirect_bad)                 state_nxt = HALT;
    else if (state == HALT)                state_nxt = HALT;
    else if (!flush && !stall && !in_range) state_nxt = HALT;
  end

  // Redirect beats everything; flush advances the PC (unless stalled) without
  // a range check, so the range is only tested on a normal fetch edge.
  always_comb begin
    pc_sel   = PC_HOLD;
    ifid_act = IFID_HOLD;
    cnt_inc  = 1'b0;
    if (redirect_ok) begin
      pc_sel   = PC_LOAD;
      ifid_act = IFID_BUBBLE;
    end else if (redirect_bad) begin
      ifid_act = IFID_BUBBLE;
    end else if (state == HALT) begin
      ifid_act = IFID_HOLD;
    end else if (flush) begin
      pc_sel   = stall ? PC_HOLD : PC_INC;
      ifid_act = IFID_BUBBLE;
    end else if (stall) begin
      ifid_act = IFID_HOLD;
    end else if (in_range) begin
      pc_sel   = PC_INC;
      ifid_act = IFID_CAPTURE;
      cnt_inc  = 1'b1;
    end else begin
      ifid_act = IFID_BUBBLE;
    end
  end

  assign halted = (state == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr  <= nop;
      ifid_pc4    <= 32'h0000_0000;
      ifid_valid  <= 1'b0;
      fetch_count <= 32'h0000_0000;
    end else begin
      unique case (ifid_act)
        IFID_CAPTURE: begin
          ifid_instr <= instr;
          ifid_pc4   <= pc_plus4;
          ifid_valid <= 1'b1;
        end
        IFID_BUBBLE: begin
          ifid_instr <= nop;
          ifid_valid <= 1'b0;
        end
        default: ;
      endcase
      if (cnt_inc) fetch_count <= fetch_count + 32'd1;
    end
  end

`ifdef FETCH_ALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            align_fault <= 1'b0;
    else if (redirect_bad) align_fault <= 1'b1;
  end
`endif

endmodule
